// File: rtl/phase_counter.sv
// phase_counter
// -------------
// Phase/address accumulator for the signal generator. Channel A (count)
// steps through 0..limit in one of four modes; channel B (count_b) is
// channel A shifted by a programmable phase offset, modulo 2^WIDTH.
// The wrap and done flags sequence the downstream waveform logic.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset, highest priority
//   en         count enable, one step per enabled cycle
//   load       synchronous load of load_val (beats en, takes no step)
//   load_val   value loaded into count
//   step_size  increment/decrement per enabled cycle
//   limit      top of the count range, inclusive (range 0..limit)
//   mode       00 WRAP, 01 BOUNCE, 10 ONESHOT, 11 DOWN
//   offset     phase offset for channel B
//   count      channel A phase (registered)
//   count_b    channel B phase, (count + offset) mod 2^WIDTH (registered)
//   wrap       one-cycle pulse on wrap or direction reversal
//   done       ONESHOT reached limit; sticky until load or rst
//   dir        current direction, 0 up / 1 down (BOUNCE)

module phase_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] step_size,
  input  logic [WIDTH-1:0] limit,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_b,
  output logic             wrap,
  output logic             done,
  output logic             dir
);

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_BOUNCE  = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_DOWN    = 2'b11
  } mode_t;

  mode_t mode_sel;
  assign mode_sel = mode_t'(mode);

  // All arithmetic is carried one bit wider than the count so that
  // limit = 2^WIDTH-1 gives a modulus of 2^WIDTH without overflow.
  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] step_x;
  logic [WIDTH:0] lim_x;
  logic [WIDTH:0] mod_x;      // M = limit + 1
  logic [WIDTH:0] sum_x;      // s = count + step_size
  logic [WIDTH:0] sum_wrap_x; // s - M, valid when s > limit
  logic [WIDTH:0] diff_x;     // count - step_size, valid when count >= step
  logic [WIDTH:0] diff_wrap_x;// count - step_size + M, valid when count < step

  assign cnt_x       = {1'b0, count};
  assign step_x      = {1'b0, step_size};
  assign lim_x       = {1'b0, limit};
  assign mod_x       = lim_x + {{WIDTH{1'b0}}, 1'b1};
  assign sum_x       = cnt_x + step_x;
  assign sum_wrap_x  = sum_x - mod_x;
  assign diff_x      = cnt_x - step_x;
  // Wraps modulo 2^(WIDTH+1) in the intermediate, but the true result lies
  // in 0..limit so the low WIDTH bits are exact.
  assign diff_wrap_x = diff_x + mod_x;

  logic [WIDTH-1:0] nxt_count;
  logic             nxt_wrap;
  logic             nxt_done;
  logic             nxt_dir;

  // Next-state selection. Exactly one correction is applied per step; a
  // step larger than M is outside the intended operating range.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    nxt_count = count;
    nxt_wrap  = 1'b0;
    nxt_done  = done;
    nxt_dir   = dir;

    if (load) begin
      nxt_count = load_val;
      nxt_dir   = 1'b0;
      nxt_done  = 1'b0;
    end else if (en) begin
      unique case (mode_sel)
        MODE_WRAP: begin
          if (sum_x > lim_x) begin
            nxt_count = sum_wrap_x[WIDTH-1:0];
            nxt_wrap  = 1'b1;
          end else begin
            nxt_count = sum_x[WIDTH-1:0];
          end
        end

        MODE_BOUNCE: begin
          // A zero step would otherwise look like an endpoint hit at
          // count = limit or count = 0 and produce spurious reversals.
          if (step_size != '0) begin
            if (!dir) begin
              if (sum_x >= lim_x) begin
                nxt_count = limit;
                nxt_dir   = 1'b1;
                nxt_wrap  = 1'b1;
              end else begin
                nxt_count = sum_x[WIDTH-1:0];
              end
            end else begin
              if (cnt_x <= step_x) begin
                nxt_count = '0;
                nxt_dir   = 1'b0;
                nxt_wrap  = 1'b1;
              end else begin
                nxt_count = diff_x[WIDTH-1:0];
              end
            end
          end
        end

        MODE_ONESHOT: begin
          // Once done, the count parks at limit until load or rst.
          if (!done) begin
            if (sum_x >= lim_x) begin
              nxt_count = limit;
              nxt_done  = 1'b1;
              nxt_wrap  = 1'b1;
            end else begin
              nxt_count = sum_x[WIDTH-1:0];
            end
          end
        end

        MODE_DOWN: begin
          if (cnt_x < step_x) begin
            nxt_count = diff_wrap_x[WIDTH-1:0];
            nxt_wrap  = 1'b1;
          end else begin
            nxt_count = diff_x[WIDTH-1:0];
          end
        end

        default: ;
      endcase
    end
  end

  // State and output registers. count_b is refreshed every cycle from the
  // next count so that it stays aligned with count and follows offset
  // changes even while counting is disabled.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (rst) begin
      count   <= '0;
      count_b <= '0;
      wrap    <= 1'b0;
      done    <= 1'b0;
      dir     <= 1'b0;
    end else begin
      count   <= nxt_count;
      count_b <= nxt_count + offset;
      wrap    <= nxt_wrap;
      done    <= nxt_done;
      dir     <= nxt_dir;
    end
  end

endmodule

// File: doc/phase_counter.md
Name: phase_counter

Overview:
- Parametrised phase/address accumulator for the signal generator; successor to the basic step counter.
- Adds programmable modulo limit, four counting modes (wrap, bounce/triangle, one-shot, down), synchronous load, and a second phase-offset output channel.
- Drives ROM address inputs; the wrap/done flags sequence the downstream waveform logic.

Parameters:
- WIDTH, 8, width of count, step, limit, offset and load value.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable; one step per enabled cycle.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value loaded into count.
- step_size  input  WIDTH  increment/decrement per enabled cycle.
- limit  input  WIDTH  top of count range, inclusive; range is 0..limit.
- mode  input  2  00 WRAP, 01 BOUNCE, 10 ONESHOT, 11 DOWN.
- offset  input  WIDTH  phase offset for channel B.
- count  output  WIDTH  channel A phase, registered.
- count_b  output  WIDTH  channel B phase, registered, (count + offset) mod 2^WIDTH.
- wrap  output  1  one-cycle pulse on wrap or direction reversal.
- done  output  1  ONESHOT reached limit; sticky.
- dir  output  1  current direction, 0 up / 1 down, used in BOUNCE.

Behaviour:
- **Reset:** count=0, count_b=0, wrap=0, done=0, dir=0. Reset overrides everything.
- **Priority:** rst > load > en. Idle hold otherwise, with wrap=0.
- **Load:**
  - count <= load_val, dir <= 0, done <= 0, wrap <= 0.
  - No step is taken in the load cycle, even if en=1.
  - load_val > limit is accepted as-is.
- **Arithmetic:**
  - All sums and compares use WIDTH+1 bits, unsigned, so limit = 2^WIDTH-1 works (modulus 2^WIDTH).
  - Let s = count + step_size and M = limit + 1.
  - Exactly one correction is applied per step. step_size > M is out of contract; the result is one correction, not a full modulo.
- **WRAP (00):** if s > limit, count <= s - M and wrap=1; else count <= s. dir unchanged.
- **BOUNCE (01):**
  - dir=0: if s >= limit, count <= limit, dir <= 1, wrap=1; else count <= s.
  - dir=1: if count <= step_size, count <= 0, dir <= 0, wrap=1; else count <= count - step_size.
  - step_size=0: count holds, no pulse.
- **ONESHOT (10):**
  - If done=1: hold.
  - Else if s >= limit: count <= limit, done <= 1, wrap=1 (single pulse).
  - Else count <= s.
  - Only load or rst clears done.
- **DOWN (11):** if count < step_size, count <= count - step_size + M and wrap=1; else count <= count - step_size.
- **wrap:** high only in the cycle after the triggering edge; never high two cycles in a row unless successive steps each wrap.
- **Mode change mid-run:** takes effect on the next enabled cycle. count, dir and done are retained; no implicit reset.
- **limit changed below the current count:** the next step applies the rule of the active mode unchanged. Example: WRAP with s > limit subtracts M once.
- **count_b:**
  - Register updated every cycle, independent of en, from (next count + current offset) mod 2^WIDTH.
  - Aligned with count (zero relative latency).
  - An offset change with en=0 appears after one edge.
  - count_b is 0 after reset.
- **Latency:** all outputs are registered; one clock from input to output.

Test Plan:
1. WRAP, limit=9, step=3, en=1 from reset -> count 3,6,9,2,5,8,1; wrap=1 on the cycles showing 2 and 1 only.
2. BOUNCE, limit=10, step=4 -> count 4,8,10,6,2,0,4; dir=1 from 10 through 2; wrap pulses at 10 and 0.
3. ONESHOT, limit=5, step=2 -> count 2,4,5,5,5; done=1 from 5 onward; single wrap pulse. Then load=1, load_val=0 -> count=0, done=0.
4. DOWN, WIDTH=8, limit=255, step=1, from 0 -> count 255 (wrap=1), 254, 253. Then WRAP mode with limit=255 at count=255, step=1 -> count 0, wrap=1.
5. WRAP, limit=255, step=1, offset=64, count reaches 200 -> count_b=8 (264 mod 256) in the same cycle. Then en=0, offset=128 -> count_b=72 after one edge while count holds at 200.
6. Precedence at count=7 with en=1, load=1, load_val=20, step=3 -> count=20 (no step). Then rst=1 with load=1, en=1 -> all outputs 0 next cycle.
